// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI4-Lite arbiter.
// One transaction in flight, fixed LSU-over-IFU priority, registered master-side requests and upstream responses.
module axi_lite_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    // fetch unit read
    input  logic [ADDR_WIDTH-1:0]   ifu_araddr,
    input  logic                    ifu_arvalid,
    output logic                    ifu_arready,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,
    output logic [1:0]              ifu_rresp,
    output logic                    ifu_rvalid,
    input  logic                    ifu_rready,
    // load/store unit read
    input  logic [ADDR_WIDTH-1:0]   lsu_araddr,
    input  logic                    lsu_arvalid,
    output logic                    lsu_arready,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic [1:0]              lsu_rresp,
    output logic                    lsu_rvalid,
    input  logic                    lsu_rready,
    // load/store unit write
    input  logic [ADDR_WIDTH-1:0]   lsu_awaddr,
    input  logic                    lsu_awvalid,
    output logic                    lsu_awready,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wstrb,
    input  logic                    lsu_wvalid,
    output logic                    lsu_wready,
    output logic [1:0]              lsu_bresp,
    output logic                    lsu_bvalid,
    input  logic                    lsu_bready,
    // memory-side master
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
);

    // state   | meaning
    // IDLE    | waiting for a request, grants are combinational
    // RD_ADDR | m_arvalid up with latched address
    // RD_DATA | m_rready up, waiting for read data
    // RD_RESP | owner's rvalid up with latched data
    // WR_REQ  | m_awvalid / m_wvalid up until each handshakes
    // WR_B    | m_bready up, waiting for write response
    // WR_RESP | lsu_bvalid up with latched bresp
    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, RD_RESP, WR_REQ, WR_B, WR_RESP
    } state_t;

    state_t                  state, stateNext;
    logic                    owner;
    logic                    awDone, wDone;
    logic [ADDR_WIDTH-1:0]   addrReg;
    logic [DATA_WIDTH-1:0]   wdataReg;
    logic [DATA_WIDTH/8-1:0] wstrbReg;
    logic [DATA_WIDTH-1:0]   rdataReg;
    logic [1:0]              rrespReg;
    logic [1:0]              brespReg;

    logic wrGrant, lsuRdGrant, ifuRdGrant;
    logic awNow, wNow;

    assign wrGrant    = lsu_awvalid & lsu_wvalid;
    assign lsuRdGrant = !wrGrant & lsu_arvalid;
    assign ifuRdGrant = !wrGrant & !lsu_arvalid & ifu_arvalid;
    assign awNow      = awDone | m_awready;
    assign wNow       = wDone | m_wready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        ifu_arready = 1'b0;
        lsu_arready = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_bvalid  = 1'b0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        case (state)
            IDLE: begin
                lsu_awready = wrGrant;
                lsu_wready  = wrGrant;
                lsu_arready = lsuRdGrant;
                ifu_arready = ifuRdGrant;
                if (wrGrant)                       stateNext = WR_REQ;
                else if (lsuRdGrant || ifuRdGrant) stateNext = RD_ADDR;
            end
            RD_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) stateNext = RD_DATA;
            end
            RD_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid) stateNext = RD_RESP;
            end
            RD_RESP: begin
                ifu_rvalid = !owner;
                lsu_rvalid = owner;
                if (owner ? lsu_rready : ifu_rready) stateNext = IDLE;
            end
            WR_REQ: begin
                m_awvalid = !awDone;
                m_wvalid  = !wDone;
                if (awNow && wNow) stateNext = WR_B;
            end
            WR_B: begin
                m_bready = 1'b1;
                if (m_bvalid) stateNext = WR_RESP;
            end
            WR_RESP: begin
                lsu_bvalid = 1'b1;
                if (lsu_bready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= 1'b0;
            awDone   <= 1'b0;
            wDone    <= 1'b0;
            addrReg  <= '0;
            wdataReg <= '0;
            wstrbReg <= '0;
            rdataReg <= '0;
            rrespReg <= '0;
            brespReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wrGrant) begin
                        addrReg  <= lsu_awaddr;
                        wdataReg <= lsu_wdata;
                        wstrbReg <= lsu_wstrb;
                    end else if (lsuRdGrant) begin
                        addrReg <= lsu_araddr;
                        owner   <= 1'b1;
                    end else if (ifuRdGrant) begin
                        addrReg <= ifu_araddr;
                        owner   <= 1'b0;
                    end
                end
                RD_DATA: begin
                    if (m_rvalid) begin
                        rdataReg <= m_rdata;
                        rrespReg <= m_rresp;
                    end
                end
                WR_REQ: begin
                    // flags clear on exit so the next write starts fresh
                    if (awNow && wNow) begin
                        awDone <= 1'b0;
                        wDone  <= 1'b0;
                    end else begin
                        awDone <= awNow;
                        wDone  <= wNow;
                    end
                end
                WR_B: begin
                    if (m_bvalid) brespReg <= m_bresp;
                end
                default: ;
            endcase
        end
    end

    assign m_araddr  = addrReg;
    assign m_awaddr  = addrReg;
    assign m_wdata   = wdataReg;
    assign m_wstrb   = wstrbReg;
    assign ifu_rdata = rdataReg;
    assign ifu_rresp = rrespReg;
    assign lsu_rdata = rdataReg;
    assign lsu_rresp = rrespReg;
    assign lsu_bresp = brespReg;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter; the memory side is driven cycle by cycle from the stimulus.
module tb_axi_lite_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ifu_araddr = '0;
    logic        ifu_arvalid = 1'b0;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready = 1'b0;
    logic [31:0] lsu_araddr = '0;
    logic        lsu_arvalid = 1'b0;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready = 1'b0;
    logic [31:0] lsu_awaddr = '0;
    logic        lsu_awvalid = 1'b0;
    logic        lsu_awready;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wstrb = '0;
    logic        lsu_wvalid = 1'b0;
    logic        lsu_wready;
    logic [1:0]  lsu_bresp;
    logic        lsu_bvalid;
    logic        lsu_bready = 1'b0;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = '0;
    logic        m_bvalid = 1'b0;
    logic        m_bready;

    int vectors = 0;
    int miscompares = 0;

    axi_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full zero-wait IFU read starting in IDLE; leaves the arbiter back in IDLE.
    task automatic ifuRead(input string tag, input logic [31:0] addr, input logic [31:0] data);
        ifu_araddr = addr; ifu_arvalid = 1'b1;
        #1 chk({tag, ".arready"}, ifu_arready, 1'b1);
        tick();
        ifu_arvalid = 1'b0; m_arready = 1'b1;
        #1 chk({tag, ".m_arvalid"}, m_arvalid, 1'b1);
        chk({tag, ".m_araddr"}, m_araddr, addr);
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = data; m_rresp = 2'b00;
        #1 chk({tag, ".m_rready"}, m_rready, 1'b1);
        tick();
        m_rvalid = 1'b0; m_rdata = '0; ifu_rready = 1'b1;
        #1 chk({tag, ".rvalid"}, ifu_rvalid, 1'b1);
        chk({tag, ".rdata"}, ifu_rdata, data);
        chk({tag, ".rresp"}, ifu_rresp, 2'b00);
        chk({tag, ".lsu_rvalid"}, lsu_rvalid, 1'b0);
        tick();
        ifu_rready = 1'b0;
        #1 chk({tag, ".rvalid_drop"}, ifu_rvalid, 1'b0);
    endtask

    initial begin
        // reset state; IDLE grant follows input valid even while in reset
        tick(); tick();
        chk("rst.m_arvalid", m_arvalid, 1'b0);
        chk("rst.m_awvalid", m_awvalid, 1'b0);
        chk("rst.m_wvalid", m_wvalid, 1'b0);
        chk("rst.m_rready", m_rready, 1'b0);
        chk("rst.m_bready", m_bready, 1'b0);
        chk("rst.rvalids", {ifu_rvalid, lsu_rvalid, lsu_bvalid}, 3'b000);
        chk("rst.m_araddr", m_araddr, 32'h0);
        chk("rst.ifu_arready_idle", ifu_arready, 1'b0);
        ifu_arvalid = 1'b1;
        #1 chk("rst.ifu_arready_follow", ifu_arready, 1'b1);
        tick();
        ifu_arvalid = 1'b0;
        rst = 1'b0;
        tick();
        chk("rst.still_idle", m_arvalid, 1'b0);

        // plain IFU read, zero-wait memory
        ifuRead("ifu1", 32'h8000_0000, 32'h0010_0093);

        // simultaneous IFU/LSU reads, LSU response backpressured 5 cycles
        lsu_araddr = 32'h8000_0100; lsu_arvalid = 1'b1;
        ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
        #1 chk("sim.lsu_arready", lsu_arready, 1'b1);
        chk("sim.ifu_arready", ifu_arready, 1'b0);
        tick();
        lsu_arvalid = 1'b0; m_arready = 1'b1;
        #1 chk("sim.m_araddr", m_araddr, 32'h8000_0100);
        chk("sim.ifu_arready_busy", ifu_arready, 1'b0);
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b10;
        #1 chk("sim.m_rready", m_rready, 1'b1);
        tick();
        m_rvalid = 1'b0; m_rdata = 32'h5555_5555; m_rresp = 2'b00;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp.lsu_rvalid", lsu_rvalid, 1'b1);
            chk("bp.lsu_rdata", lsu_rdata, 32'hDEAD_BEEF);
            chk("bp.ifu_rvalid", ifu_rvalid, 1'b0);
            chk("bp.ifu_arready", ifu_arready, 1'b0);
            tick();
        end
        lsu_rready = 1'b1;
        #1 chk("bp.lsu_rvalid_end", lsu_rvalid, 1'b1);
        chk("bp.lsu_rresp", lsu_rresp, 2'b10);
        chk("bp.ifu_arready_hold", ifu_arready, 1'b0);
        tick();
        lsu_rready = 1'b0;
        #1 chk("sim.ifu_arready_after", ifu_arready, 1'b1);
        chk("sim.lsu_rvalid_drop", lsu_rvalid, 1'b0);
        tick();
        ifu_arvalid = 1'b0; m_arready = 1'b1;
        #1 chk("sim.ifu_m_araddr", m_araddr, 32'h8000_0004);
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_0013;
        tick();
        m_rvalid = 1'b0; m_rdata = '0; ifu_rready = 1'b1;
        #1 chk("sim.ifu_rvalid", ifu_rvalid, 1'b1);
        chk("sim.ifu_rdata", ifu_rdata, 32'h0000_0013);
        chk("sim.ifu_rresp", ifu_rresp, 2'b00);
        tick();
        ifu_rready = 1'b0;

        // LSU write, m_awready two cycles after m_wready
        lsu_awaddr = 32'h8000_0200; lsu_awvalid = 1'b1;
        lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hF; lsu_wvalid = 1'b1;
        #1 chk("wr.awready", lsu_awready, 1'b1);
        chk("wr.wready", lsu_wready, 1'b1);
        tick();
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
        m_wready = 1'b1;
        #1 chk("wr.m_awvalid1", m_awvalid, 1'b1);
        chk("wr.m_wvalid1", m_wvalid, 1'b1);
        chk("wr.m_awaddr", m_awaddr, 32'h8000_0200);
        chk("wr.m_wdata", m_wdata, 32'h1234_5678);
        chk("wr.m_wstrb", m_wstrb, 4'hF);
        tick();
        m_wready = 1'b0;
        #1 chk("wr.m_wvalid_drop", m_wvalid, 1'b0);
        chk("wr.m_awvalid2", m_awvalid, 1'b1);
        chk("wr.m_bready_early2", m_bready, 1'b0);
        tick();
        m_awready = 1'b1;
        #1 chk("wr.m_awvalid3", m_awvalid, 1'b1);
        chk("wr.m_bready_early3", m_bready, 1'b0);
        chk("wr.m_awaddr_stable", m_awaddr, 32'h8000_0200);
        tick();
        m_awready = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00;
        #1 chk("wr.m_bready", m_bready, 1'b1);
        chk("wr.m_awvalid_drop", m_awvalid, 1'b0);
        tick();
        m_bvalid = 1'b0; m_bresp = 2'b11; lsu_bready = 1'b1;
        #1 chk("wr.lsu_bvalid", lsu_bvalid, 1'b1);
        chk("wr.lsu_bresp", lsu_bresp, 2'b00);
        tick();
        lsu_bready = 1'b0; m_bresp = 2'b00;
        #1 chk("wr.lsu_bvalid_drop", lsu_bvalid, 1'b0);

        // reset asserted while in RD_DATA
        ifu_araddr = 32'h8000_0008; ifu_arvalid = 1'b1;
        tick();
        ifu_arvalid = 1'b0; m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        #1 chk("mrst.in_rd_data", m_rready, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("mrst.m_rready", m_rready, 1'b0);
        chk("mrst.m_valids", {m_arvalid, m_awvalid, m_wvalid, m_bready}, 4'b0000);
        chk("mrst.up_valids", {ifu_rvalid, lsu_rvalid, lsu_bvalid}, 3'b000);
        chk("mrst.rdata_cleared", ifu_rdata, 32'h0);
        ifuRead("ifu_post_rst", 32'h8000_000C, 32'h0000_0113);

        // lone awvalid (and lone wvalid) must not be granted
        lsu_awaddr = 32'h8000_0300; lsu_awvalid = 1'b1;
        #1 chk("lone.awready", lsu_awready, 1'b0);
        chk("lone.wready", lsu_wready, 1'b0);
        tick();
        #1 chk("lone.no_m_awvalid", m_awvalid, 1'b0);
        ifuRead("lone.ifu", 32'h8000_0010, 32'h00A0_0513);
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b1;
        #1 chk("lone_w.wready", lsu_wready, 1'b0);
        chk("lone_w.awready", lsu_awready, 1'b0);
        lsu_wvalid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master to one-slave AXI4-Lite arbiter sitting directly below the core's fetch unit and load/store unit. It merges the fetch unit's read channel and the LSU's read and write channels onto the single memory port. It serialises transactions with one outstanding at a time, fixed LSU-over-IFU priority, and fully registered master-side requests and upstream responses.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- ifu_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  fetch read-address channel
- ifu_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  fetch read-data channel
- lsu_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  LSU read-address channel
- lsu_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  LSU read-data channel
- lsu_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  LSU write-address channel
- lsu_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  LSU write-data channel
- lsu_bresp/bvalid/bready  out/out/in  2/1/1  LSU write-response channel
- m_araddr/arvalid/arready, m_rdata/rresp/rvalid/rready  AXI4-Lite read master toward memory
- m_awaddr/awvalid/awready, m_wdata/wstrb/wvalid/wready, m_bresp/bvalid/bready  AXI4-Lite write master toward memory

## Operation
- States: IDLE, RD_ADDR, RD_DATA, RD_RESP, WR_REQ, WR_B, WR_RESP. A 1-bit owner register (0 = IFU, 1 = LSU) is loaded at each read grant.
- **IDLE.** Grant priority is:
  - LSU write, when lsu_awvalid & lsu_wvalid are both high;
  - else LSU read, when lsu_arvalid;
  - else IFU read, when ifu_arvalid.
- **Grant handshake.** Only the winner sees its ready(s) high, combinationally in IDLE:
  - lsu_awready and lsu_wready assert together; a lone awvalid or wvalid is never accepted.
  - On the handshake, address, wdata and wstrb are latched.
  - Next state is RD_ADDR or WR_REQ.
- **RD_ADDR.** m_arvalid=1 with the latched address; on m_arready go to RD_DATA.
- **RD_DATA.** m_rready=1. On m_rvalid, latch rdata and rresp and go to RD_RESP.
- **RD_RESP.** The owner's rvalid=1 with the latched data; the other master's rvalid stays 0. On the owner's rready go to IDLE.
- **WR_REQ.** m_awvalid and m_wvalid each stay high until their own handshake; aw_done and w_done flags record completion. When both are done, or both complete in the same cycle, go to WR_B.
- **WR_B.** m_bready=1. On m_bvalid, latch bresp and go to WR_RESP.
- **WR_RESP.** lsu_bvalid=1; on lsu_bready go to IDLE.
- rresp and bresp pass through unmodified; no error generation or address decode.
- In every state other than the owning one, all upstream readies/valids and all master valids/readies are 0.
- Priority is fixed. IFU starvation is acceptable because the LSU cannot issue back-to-back without the pipeline advancing.

## Timing
- **Reset.** State=IDLE, owner=0, aw_done=w_done=0, latched data/addr/strb/resp=0, and all valid/ready outputs 0 except the combinational IDLE grants, which follow the input valids.
- **Reset mid-transaction** aborts unconditionally: all m_*valid drop the next cycle and the in-flight response is discarded. Memory must also be reset.
- **Read latency** with zero-wait memory:
  - cycle 0: upstream AR handshake in IDLE;
  - cycle 1: m_arvalid and m_arready;
  - cycle 2: m_rvalid;
  - cycle 3: upstream rvalid.
  - Each memory wait cycle adds one cycle.
- **Write latency**, same shape: cycle 0 grant, cycle 1 AW/W, cycle 2 B, cycle 3 lsu_bvalid.
- **Turnaround.** The upstream response handshake in cycle N returns to IDLE, and a new grant is possible in cycle N+1. Minimum spacing between grants is therefore 4 cycles.
- **Stability.** Master-side address, data and strobe come from registers and are stable while their valid is high. Master valids never drop before their handshake.
- **Backpressure.** Upstream rready/bready low holds RD_RESP/WR_RESP indefinitely with data stable.

## Test plan
- **IFU read:** ifu_araddr=0x8000_0000; memory returns 0x0010_0093 with zero wait. Required: ifu_rvalid in cycle 3 with that data, rresp=0, and lsu_rvalid never asserted.
- **Simultaneous requests:** ifu_arvalid and lsu_arvalid both rise in the same cycle (LSU addr 0x8000_0100, data 0xDEAD_BEEF). Required: the LSU is served first (lsu_arready only); ifu_arready asserts on the first IDLE after lsu_rvalid&rready; the IFU read then completes.
- **Skewed write handshakes:** LSU write of 0x1234_5678, strb 0xF, to 0x8000_0200; memory delays m_awready by 2 cycles relative to m_wready. Required: m_wvalid drops after its handshake, m_awvalid holds, WR_B is entered only after both are done, and lsu_bvalid asserts with bresp=0.
- **Response backpressure:** lsu_rready held low 5 cycles in RD_RESP. Required: lsu_rvalid and lsu_rdata stay stable, and a concurrent ifu_arvalid is not granted until the LSU handshake completes.
- **Reset mid-read:** assert rst in RD_DATA. Required: the next cycle has state IDLE with all m_* and upstream valids 0; a post-reset IFU read completes normally.
- **Lone awvalid:** lsu_awvalid high with lsu_wvalid low. Required: no grant; with ifu_arvalid also high, the IFU read is granted.
